// File: rtl/csr_unit.sv
// ---------------------------------------------------------------------------
// csr_unit
//
// Machine-mode control/status register file for the RV32 execute stage.
// It answers the CSR control bundle from decode (CSRRW/CSRRS/CSRRC). It also
// keeps the free-running cycle/instret counters and the trap entry/return
// state, and hands mtvec/mepc to fetch.
//
// Optional feature macro: CSR_COUNTERS_EN
//   defined   -> 64-bit mcycle/minstret counters plus their 0xCxx shadows
//   undefined -> no counter flops; counter addresses read 0, and writes to
//                0xBxx are silently ignored
//
// Ports
//   clk            system clock, all state updates on the rising edge
//   rst            asynchronous active-low reset
//   CSR_reg_wr     write request this cycle
//   CSR_reg_rd     read request this cycle
//   CSR_wd_select  00 RW, 01 RS (set), 10 RC (clear), 11 no write
//   RD1_RS1_sel    operand source: 0 RS1_data, 1 zero-extended RS1_uimm
//   CSR_addr       12-bit CSR address
//   RS1_data       forwarded rs1 value
//   RS1_uimm       rs1 field used as an immediate
//   Stall          hold: blocks CSR writes and the minstret increment
//   instr_retire   one instruction retires this cycle
//   trap_en        take a trap this cycle
//   trap_cause     value loaded into mcause on a trap
//   trap_pc        value loaded into mepc on a trap
//   mret_en        execute MRET this cycle
//   CSR_rdata      pre-write CSR value (0 when not reading or illegal)
//   CSR_illegal    illegal access this cycle
//   mtvec_o        current mtvec
//   mepc_o         current mepc
//   mie_global     mstatus.MIE
// ---------------------------------------------------------------------------
module csr_unit #(
  parameter logic [31:0] HART_ID  = 32'd0,
  parameter logic [31:0] MISA_VAL = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CSR_reg_wr,
  input  logic        CSR_reg_rd,
  input  logic [1:0]  CSR_wd_select,
  input  logic        RD1_RS1_sel,
  input  logic [11:0] CSR_addr,
  input  logic [31:0] RS1_data,
  input  logic [4:0]  RS1_uimm,
  input  logic        Stall,
  input  logic        instr_retire,
  input  logic        trap_en,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic        mret_en,
  output logic [31:0] CSR_rdata,
  output logic        CSR_illegal,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic        mie_global
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MISA     = 12'h301;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRH  = 12'hB82;
  localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH   = 12'hC80;
  localparam logic [11:0] ADDR_INSTRET  = 12'hC02;
  localparam logic [11:0] ADDR_INSTRETH = 12'hC82;
  localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

  localparam logic [31:0] MSTATUS_MIE  = 32'h0000_0008;
  localparam logic [31:0] MSTATUS_MPIE = 32'h0000_0080;
  localparam logic [31:0] MSTATUS_MASK = 32'h0000_0088;
  localparam logic [31:0] MIE_MASK     = 32'h0000_0888;
  localparam logic [31:0] ALIGN_MASK   = 32'hFFFF_FFFC;

  logic [31:0] operand;
  logic [31:0] oldValue;
  logic [31:0] writeValue;
  logic        addrImpl;
  logic        illegalRaw;
  logic        writeEn;
  logic        wrMstatus;
  logic        wrMie;
  logic        wrMtvec;
  logic        wrMscratch;
  logic        wrMepc;
  logic        wrMcause;

  // Registers are kept 32 bits wide with their masks applied on every load;
  // the constant-zero bits are trimmed by synthesis.
  logic [31:0] mstatusReg;
  logic [31:0] mieReg;
  logic [31:0] mtvecReg;
  logic [31:0] mscratchReg;
  logic [31:0] mepcReg;
  logic [31:0] mcauseReg;

  logic [63:0] mcycleVal;
  logic [63:0] minstretVal;

  assign operand = RD1_RS1_sel ? {27'd0, RS1_uimm} : RS1_data;

  // Address decode and read mux. Every address that is not listed here is
  // unimplemented. The counter addresses stay implemented even when the
  // counters are compiled out.
  always_comb begin
    addrImpl = 1'b1;
    oldValue = 32'd0;
    case (CSR_addr)
      ADDR_MSTATUS:               oldValue = mstatusReg;
      ADDR_MISA:                  oldValue = MISA_VAL;
      ADDR_MIE:                   oldValue = mieReg;
      ADDR_MTVEC:                 oldValue = mtvecReg;
      ADDR_MSCRATCH:              oldValue = mscratchReg;
      ADDR_MEPC:                  oldValue = mepcReg;
      ADDR_MCAUSE:                oldValue = mcauseReg;
      ADDR_MCYCLE,   ADDR_CYCLE:    oldValue = mcycleVal[31:0];
      ADDR_MCYCLEH,  ADDR_CYCLEH:   oldValue = mcycleVal[63:32];
      ADDR_MINSTRET, ADDR_INSTRET:  oldValue = minstretVal[31:0];
      ADDR_MINSTRH,  ADDR_INSTRETH: oldValue = minstretVal[63:32];
      ADDR_MHARTID:               oldValue = HART_ID;
      default:                    addrImpl = 1'b0;
    endcase
  end

  // Read-modify-write value, before the per-register mask is applied.
  always_comb begin
    writeValue = operand;
    case (CSR_wd_select)
      2'b01:   writeValue = oldValue | operand;
      2'b10:   writeValue = oldValue & ~operand;
      default: writeValue = operand;
    endcase
  end

  // The 0xC00-0xFFF range is read-only. Outputs are forced to zero while
  // reset is held, so constant registers such as misa cannot leak through.
  assign illegalRaw  = ((CSR_reg_rd | CSR_reg_wr) & ~addrImpl) |
                       (CSR_reg_wr & (CSR_addr[11:10] == 2'b11));
  assign CSR_illegal = rst & illegalRaw;
  assign CSR_rdata   = (rst && CSR_reg_rd && !illegalRaw) ? oldValue : 32'd0;

  // A trap always wins over a CSR write. MRET only blocks mstatus writes.
  assign writeEn    = CSR_reg_wr & ~illegalRaw & ~Stall & ~trap_en &
                      (CSR_wd_select != 2'b11);
  assign wrMstatus  = writeEn & (CSR_addr == ADDR_MSTATUS) & ~mret_en;
  assign wrMie      = writeEn & (CSR_addr == ADDR_MIE);
  assign wrMtvec    = writeEn & (CSR_addr == ADDR_MTVEC);
  assign wrMscratch = writeEn & (CSR_addr == ADDR_MSCRATCH);
  assign wrMepc     = writeEn & (CSR_addr == ADDR_MEPC);
  assign wrMcause   = writeEn & (CSR_addr == ADDR_MCAUSE);

  // mstatus: on trap entry MPIE captures MIE and MIE is cleared. On MRET,
  // MIE is restored from MPIE and MPIE is set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mstatusReg <= 32'd0;
    end else if (trap_en) begin
      mstatusReg <= mstatusReg[3] ? MSTATUS_MPIE : 32'd0;
    end else if (mret_en) begin
      mstatusReg <= MSTATUS_MPIE | (mstatusReg[7] ? MSTATUS_MIE : 32'd0);
    end else if (wrMstatus) begin
      mstatusReg <= writeValue & MSTATUS_MASK;
    end
  end

  // mepc and mcause are loaded by trap entry, or by an ordinary CSR write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mepcReg   <= 32'd0;
      mcauseReg <= 32'd0;
    end else if (trap_en) begin
      mepcReg   <= trap_pc & ALIGN_MASK;
      mcauseReg <= trap_cause;
    end else begin
      if (wrMepc)   mepcReg   <= writeValue & ALIGN_MASK;
      if (wrMcause) mcauseReg <= writeValue;
    end
  end

  // Registers that only software writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mieReg      <= 32'd0;
      mtvecReg    <= 32'd0;
      mscratchReg <= 32'd0;
    end else begin
      if (wrMie)      mieReg      <= writeValue & MIE_MASK;
      if (wrMtvec)    mtvecReg    <= writeValue & ALIGN_MASK;
      if (wrMscratch) mscratchReg <= writeValue;
    end
  end

`ifdef CSR_COUNTERS_EN
  logic [31:0] mcycleLo;
  logic [31:0] mcycleHi;
  logic [31:0] minstretLo;
  logic [31:0] minstretHi;
  logic [63:0] mcycleInc;
  logic [63:0] minstretInc;
  logic        wrMcycle;
  logic        wrMcycleh;
  logic        wrMinstret;
  logic        wrMinstreth;

  assign mcycleVal   = {mcycleHi, mcycleLo};
  assign minstretVal = {minstretHi, minstretLo};
  assign mcycleInc   = mcycleVal + 64'd1;
  assign minstretInc = minstretVal + {63'd0, instr_retire & ~Stall};

  assign wrMcycle    = writeEn & (CSR_addr == ADDR_MCYCLE);
  assign wrMcycleh   = writeEn & (CSR_addr == ADDR_MCYCLEH);
  assign wrMinstret  = writeEn & (CSR_addr == ADDR_MINSTRET);
  assign wrMinstreth = writeEn & (CSR_addr == ADDR_MINSTRH);

  // Each half either takes the written value or the full 64-bit increment.
  // This keeps the low-to-high carry in the same cycle and lets the
  // unwritten half keep counting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcycleLo   <= 32'd0;
      mcycleHi   <= 32'd0;
      minstretLo <= 32'd0;
      minstretHi <= 32'd0;
    end else begin
      mcycleLo   <= wrMcycle    ? writeValue : mcycleInc[31:0];
      mcycleHi   <= wrMcycleh   ? writeValue : mcycleInc[63:32];
      minstretLo <= wrMinstret  ? writeValue : minstretInc[31:0];
      minstretHi <= wrMinstreth ? writeValue : minstretInc[63:32];
    end
  end
`else
  logic unusedCounterInputs;

  assign mcycleVal           = 64'd0;
  assign minstretVal         = 64'd0;
  assign unusedCounterInputs = instr_retire;
`endif

  assign mtvec_o    = mtvecReg;
  assign mepc_o     = mepcReg;
  assign mie_global = mstatusReg[3];

endmodule

// File: tb/tb_csr_unit.sv
// ---------------------------------------------------------------------------
// tb_csr_unit
//
// Self-checking bench for csr_unit. A behavioural model follows the CSR file
// as a set of named values and 64-bit counters. On every falling edge, one
// compare process checks all DUT outputs against that model. Directed
// vectors also carry hand-computed literal expectations.
// Honours CSR_COUNTERS_EN in the same way as the design.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_csr_unit;

`ifdef CSR_COUNTERS_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk           = 1'b0;
  logic        rst           = 1'b0;
  logic        CSR_reg_wr    = 1'b0;
  logic        CSR_reg_rd    = 1'b0;
  logic [1:0]  CSR_wd_select = 2'b00;
  logic        RD1_RS1_sel   = 1'b0;
  logic [11:0] CSR_addr      = 12'd0;
  logic [31:0] RS1_data      = 32'd0;
  logic [4:0]  RS1_uimm      = 5'd0;
  logic        Stall         = 1'b0;
  logic        instr_retire  = 1'b0;
  logic        trap_en       = 1'b0;
  logic [31:0] trap_cause    = 32'd0;
  logic [31:0] trap_pc       = 32'd0;
  logic        mret_en       = 1'b0;
  logic [31:0] CSR_rdata;
  logic        CSR_illegal;
  logic [31:0] mtvec_o;
  logic [31:0] mepc_o;
  logic        mie_global;

  int checkCount = 0;
  int errorCount = 0;

  // Model state
  logic        modelMie       = 1'b0;
  logic        modelMpie      = 1'b0;
  logic [31:0] modelIntEnable = 32'd0;
  logic [31:0] modelMtvec     = 32'd0;
  logic [31:0] modelMscratch  = 32'd0;
  logic [31:0] modelMepc      = 32'd0;
  logic [31:0] modelMcause    = 32'd0;
  logic [63:0] modelCycle     = 64'd0;
  logic [63:0] modelInstret   = 64'd0;

  csr_unit dut (
    .clk          (clk),
    .rst          (rst),
    .CSR_reg_wr   (CSR_reg_wr),
    .CSR_reg_rd   (CSR_reg_rd),
    .CSR_wd_select(CSR_wd_select),
    .RD1_RS1_sel  (RD1_RS1_sel),
    .CSR_addr     (CSR_addr),
    .RS1_data     (RS1_data),
    .RS1_uimm     (RS1_uimm),
    .Stall        (Stall),
    .instr_retire (instr_retire),
    .trap_en      (trap_en),
    .trap_cause   (trap_cause),
    .trap_pc      (trap_pc),
    .mret_en      (mret_en),
    .CSR_rdata    (CSR_rdata),
    .CSR_illegal  (CSR_illegal),
    .mtvec_o      (mtvec_o),
    .mepc_o       (mepc_o),
    .mie_global   (mie_global)
  );

  always #5 clk = ~clk;

  function automatic bit modelImpl(input logic [11:0] a);
    return a inside {12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                     12'h342, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00,
                     12'hC80, 12'hC02, 12'hC82, 12'hF14};
  endfunction

  function automatic logic [31:0] modelValue(input logic [11:0] a);
    case (a)
      12'h300:          return {24'd0, modelMpie, 3'd0, modelMie, 3'd0};
      12'h301:          return 32'h4000_0100;
      12'h304:          return modelIntEnable;
      12'h305:          return modelMtvec;
      12'h340:          return modelMscratch;
      12'h341:          return modelMepc;
      12'h342:          return modelMcause;
      12'hB00, 12'hC00: return modelCycle[31:0];
      12'hB80, 12'hC80: return modelCycle[63:32];
      12'hB02, 12'hC02: return modelInstret[31:0];
      12'hB82, 12'hC82: return modelInstret[63:32];
      default:          return 32'd0;
    endcase
  endfunction

  function automatic bit modelIllegal();
    if (!rst) return 1'b0;
    return ((CSR_reg_rd || CSR_reg_wr) && !modelImpl(CSR_addr)) ||
           (CSR_reg_wr && CSR_addr[11:10] == 2'b11);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model update: the architectural effect of one clock edge.
  always @(posedge clk or negedge rst) begin : modelStep
    logic [31:0] opv, oldv, nv;
    logic [63:0] cycNext, instNext;
    bit          doWrite;
    if (!rst) begin
      modelMie       = 1'b0;
      modelMpie      = 1'b0;
      modelIntEnable = 32'd0;
      modelMtvec     = 32'd0;
      modelMscratch  = 32'd0;
      modelMepc      = 32'd0;
      modelMcause    = 32'd0;
      modelCycle     = 64'd0;
      modelInstret   = 64'd0;
    end else begin
      opv  = RD1_RS1_sel ? {27'd0, RS1_uimm} : RS1_data;
      oldv = modelValue(CSR_addr);
      case (CSR_wd_select)
        2'b00:   nv = opv;
        2'b01:   nv = oldv | opv;
        2'b10:   nv = oldv & ~opv;
        default: nv = oldv;
      endcase
      doWrite = CSR_reg_wr && !modelIllegal() && !Stall && !trap_en &&
                CSR_wd_select != 2'b11;

      cycNext  = modelCycle + 64'd1;
      instNext = modelInstret + ((instr_retire && !Stall) ? 64'd1 : 64'd0);
      if (doWrite) begin
        case (CSR_addr)
          12'hB00: cycNext[31:0]   = nv;
          12'hB80: cycNext[63:32]  = nv;
          12'hB02: instNext[31:0]  = nv;
          12'hB82: instNext[63:32] = nv;
          default: ;
        endcase
      end
      if (CNT_EN) begin
        modelCycle   = cycNext;
        modelInstret = instNext;
      end

      if (trap_en) begin
        modelMpie   = modelMie;
        modelMie    = 1'b0;
        modelMepc   = {trap_pc[31:2], 2'b00};
        modelMcause = trap_cause;
      end else begin
        if (mret_en) begin
          modelMie  = modelMpie;
          modelMpie = 1'b1;
        end
        if (doWrite) begin
          case (CSR_addr)
            12'h300: if (!mret_en) begin
                       modelMie  = nv[3];
                       modelMpie = nv[7];
                     end
            12'h304: modelIntEnable = nv & 32'h0000_0888;
            12'h305: modelMtvec     = {nv[31:2], 2'b00};
            12'h340: modelMscratch  = nv;
            12'h341: modelMepc      = {nv[31:2], 2'b00};
            12'h342: modelMcause    = nv;
            default: ;
          endcase
        end
      end
    end
  end

  // Compare process: all outputs against the model on every falling edge.
  always @(negedge clk) begin : compareStep
    logic        expIll;
    logic [31:0] expRdata;
    expIll   = modelIllegal();
    expRdata = (rst && CSR_reg_rd && !expIll) ? modelValue(CSR_addr) : 32'd0;
    checkOutput("cmp CSR_rdata", CSR_rdata, expRdata);
    checkOutput("cmp CSR_illegal", {31'd0, CSR_illegal}, {31'd0, expIll});
    checkOutput("cmp mtvec_o", mtvec_o, modelMtvec);
    checkOutput("cmp mepc_o", mepc_o, modelMepc);
    checkOutput("cmp mie_global", {31'd0, mie_global}, {31'd0, modelMie});
  end

  task automatic applyStimulus(input logic wr, input logic rd, input logic [1:0] ws,
                               input logic sel, input logic [11:0] addr,
                               input logic [31:0] data, input logic [4:0] uimm);
    @(posedge clk);
    #1;
    CSR_reg_wr    = wr;
    CSR_reg_rd    = rd;
    CSR_wd_select = ws;
    RD1_RS1_sel   = sel;
    CSR_addr      = addr;
    RS1_data      = data;
    RS1_uimm      = uimm;
    trap_en       = 1'b0;
    mret_en       = 1'b0;
    Stall         = 1'b0;
  endtask

  task automatic idleRead(input logic [11:0] addr);
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, addr, 32'd0, 5'd0);
  endtask

  task automatic checkRead(input string name, input logic [31:0] expected);
    @(negedge clk);
    checkOutput(name, CSR_rdata, expected);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset held, with a read of misa pending: everything must read 0.
    CSR_reg_rd = 1'b1;
    CSR_addr   = 12'h301;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset rdata", CSR_rdata, 32'd0);
    checkOutput("reset illegal", {31'd0, CSR_illegal}, 32'd0);
    checkOutput("reset mtvec_o", mtvec_o, 32'd0);
    checkOutput("reset mepc_o", mepc_o, 32'd0);
    checkOutput("reset mie_global", {31'd0, mie_global}, 32'd0);
    @(posedge clk);
    #1;
    rst        = 1'b1;
    CSR_reg_rd = 1'b0;

    // RW to mscratch
    applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 12'h340, 32'hDEAD_BEEF, 5'd0);
    checkRead("rw old value", 32'd0);
    idleRead(12'h340);
    checkRead("rw new value", 32'hDEAD_BEEF);
    idleRead(12'h301);
    checkRead("misa", 32'h4000_0100);

    // RS to mstatus with uimm
    applyStimulus(1'b1, 1'b0, 2'b01, 1'b1, 12'h300, 32'd0, 5'h1F);
    idleRead(12'h300);
    checkRead("rs mstatus", 32'h0000_0008);
    checkOutput("rs mie_global", {31'd0, mie_global}, 32'd1);

    // mie mask
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 12'h304, 32'hFFFF_FFFF, 5'd0);
    idleRead(12'h304);
    checkRead("mie mask", 32'h0000_0888);

    // mtvec RW then RC
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 12'h305, 32'hFFFF_FFFF, 5'd0);
    applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 12'h305, 32'h0000_000F, 5'd0);
    checkRead("rc old mtvec", 32'hFFFF_FFFC);
    idleRead(12'h305);
    checkRead("rc mtvec", 32'hFFFF_FFF0);
    checkOutput("rc mtvec_o", mtvec_o, 32'hFFFF_FFF0);

    // Counter carry and write priority
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 12'hB80, 32'd0, 5'd0);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 12'hB00, 32'hFFFF_FFFF, 5'd0);
    idleRead(12'hB00);
    checkRead("cycle pre-wrap", CNT_EN ? 32'hFFFF_FFFF : 32'd0);
    idleRead(12'hB00);
    checkRead("cycle wrapped lo", 32'd0);
    idleRead(12'hB80);
    checkRead("cycle carry hi", CNT_EN ? 32'd1 : 32'd0);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 12'hB00, 32'd5, 5'd0);
    idleRead(12'hB00);
    checkRead("cycle write priority", CNT_EN ? 32'd5 : 32'd0);

    // Trap beats a simultaneous write to mepc
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 12'h341, 32'd0, 5'd0);
    trap_en    = 1'b1;
    trap_pc    = 32'h0000_1236;
    trap_cause = 32'd11;
    idleRead(12'h341);
    checkRead("trap mepc", 32'h0000_1234);
    checkOutput("trap mepc_o", mepc_o, 32'h0000_1234);
    idleRead(12'h342);
    checkRead("trap mcause", 32'd11);
    idleRead(12'h300);
    checkRead("trap mstatus", 32'h0000_0080);
    checkOutput("trap mie_global", {31'd0, mie_global}, 32'd0);

    // MRET, with a dropped mstatus write
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 12'h300, 32'd0, 5'd0);
    mret_en = 1'b1;
    idleRead(12'h300);
    checkRead("mret mstatus", 32'h0000_0088);
    checkOutput("mret mie_global", {31'd0, mie_global}, 32'd1);

    // Illegal accesses
    applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 12'hC00, 32'h0000_1234, 5'd0);
    @(negedge clk);
    checkOutput("illegal shadow write", {31'd0, CSR_illegal}, 32'd1);
    checkOutput("illegal shadow rdata", CSR_rdata, 32'd0);
    idleRead(12'h7C0);
    @(negedge clk);
    checkOutput("illegal unimpl read", {31'd0, CSR_illegal}, 32'd1);
    checkOutput("illegal unimpl rdata", CSR_rdata, 32'd0);
    applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 12'h301, 32'd0, 5'd0);
    @(negedge clk);
    checkOutput("misa write legal", {31'd0, CSR_illegal}, 32'd0);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 12'hB82, 32'h0000_0077, 5'd0);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 12'hB82, 32'd0, 5'd0);

    // Retire three instructions, then a stalled cycle
    idleRead(12'h300);
    instr_retire = 1'b1;
    idleRead(12'h300);
    idleRead(12'h300);
    applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 12'h340, 32'h1234_5678, 5'd0);
    Stall = 1'b1;
    checkRead("stall old value", 32'hDEAD_BEEF);
    idleRead(12'h340);
    instr_retire = 1'b0;
    checkRead("stall no write", 32'hDEAD_BEEF);
    idleRead(12'hB02);
    checkRead("stall minstret", CNT_EN ? 32'd3 : 32'd0);
    idleRead(12'hC02);
    checkRead("instret shadow", CNT_EN ? 32'd3 : 32'd0);

    // Asynchronous reset in the middle of a cycle
    idleRead(12'h340);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async rdata", CSR_rdata, 32'd0);
    checkOutput("async mtvec_o", mtvec_o, 32'd0);
    checkOutput("async mepc_o", mepc_o, 32'd0);
    checkOutput("async mie_global", {31'd0, mie_global}, 32'd0);
    CSR_addr = 12'h7C0;
    #1;
    checkOutput("async illegal", {31'd0, CSR_illegal}, 32'd0);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    CSR_addr = 12'hB00;
    checkRead("cycle after reset", 32'd0);
    idleRead(12'hB00);
    checkRead("first increment", CNT_EN ? 32'd1 : 32'd0);
    idleRead(12'h340);
    checkRead("mscratch after reset", 32'd0);

    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 12'd0, 32'd0, 5'd0);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
